// File: rtl/riscv_wb_checker.sv
// Writeback-snooping self-check harness for the pipelined RV32 core: shadow regfile, quiescence/timeout
// end detection, expected-table compare. Define WBCHK_X0_FAULT_EN to flag non-zero writes to x0.
module riscv_wb_checker #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int QUIET   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    wb_en,
    input  logic [$clog2(NREG)-1:0] wb_rd,
    input  logic [XLEN-1:0]         wb_data,
    input  logic                    exp_we,
    input  logic [$clog2(NREG)-1:0] exp_idx,
    input  logic [XLEN-1:0]         exp_val,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [1:0]              fail_code,
    output logic [$clog2(NREG)-1:0] fail_idx,
    output logic [XLEN-1:0]         fail_got,
    output logic [XLEN-1:0]         fail_exp,
    output logic [15:0]             retire_count,
    output logic [15:0]             cycle_count
);
    localparam int IW = $clog2(NREG);
    localparam int QW = $clog2(QUIET + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;
    typedef enum logic [1:0] {FC_NONE, FC_MISMATCH, FC_TIMEOUT, FC_X0} fail_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] shadow_q  [NREG];
    logic [XLEN-1:0] exp_val_q [NREG];
    logic [NREG-1:0] exp_vld_q;
    logic [QW-1:0]   quiet_q, quiet_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [15:0]     retire_q, retire_d, cycle_q, cycle_d;
    fail_t           fail_code_q, fail_code_d;
    logic [IW-1:0]   fail_idx_q, fail_idx_d;
    logic [XLEN-1:0] fail_got_q, fail_got_d, fail_exp_q, fail_exp_d;

    logic idle_or_done, start_run, exp_accept, quiesce, timeout;

    assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
    assign start_run    = idle_or_done && start;
    assign exp_accept   = idle_or_done && exp_we;
    assign quiesce      = (state_q == S_RUN) && !wb_en && (quiet_q == QW'(QUIET - 1));
    assign timeout      = (state_q == S_RUN) && (cycle_q == 16'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_RUN;
            S_RUN: begin
                if (timeout)      state_d = S_DONE;
                else if (quiesce) state_d = S_CHECK;
            end
            S_CHECK: if (idx_q == IW'(NREG - 1)) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        retire_d    = retire_q;
        cycle_d     = cycle_q;
        quiet_d     = quiet_q;
        idx_d       = idx_q;
        fail_code_d = fail_code_q;
        fail_idx_d  = fail_idx_q;
        fail_got_d  = fail_got_q;
        fail_exp_d  = fail_exp_q;
        if (start_run) begin
            retire_d    = '0;
            cycle_d     = '0;
            quiet_d     = '0;
            idx_d       = '0;
            fail_code_d = FC_NONE;
            fail_idx_d  = '0;
            fail_got_d  = '0;
            fail_exp_d  = '0;
        end else if (state_q == S_RUN) begin
            if (cycle_q != 16'hFFFF) cycle_d = cycle_q + 16'd1;
            if (wb_en) begin
                if (retire_q != 16'hFFFF) retire_d = retire_q + 16'd1;
                quiet_d = '0;
            end else begin
                quiet_d = quiet_q + QW'(1);
            end
`ifdef WBCHK_X0_FAULT_EN
            if (wb_en && (wb_rd == '0) && (wb_data != '0) && (fail_code_q == FC_NONE)) begin
                fail_code_d = FC_X0;
                fail_idx_d  = '0;
            end
`endif
            // An earlier x0 fault keeps its code; otherwise the timeout is reported.
            if (timeout && (fail_code_d == FC_NONE)) fail_code_d = FC_TIMEOUT;
        end else if (state_q == S_CHECK) begin
            idx_d = idx_q + IW'(1);
            if (exp_vld_q[idx_q] && (exp_val_q[idx_q] != shadow_q[idx_q])
                && (fail_code_q == FC_NONE)) begin
                fail_code_d = FC_MISMATCH;
                fail_idx_d  = idx_q;
                fail_got_d  = shadow_q[idx_q];
                fail_exp_d  = exp_val_q[idx_q];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            retire_q    <= '0;
            cycle_q     <= '0;
            quiet_q     <= '0;
            idx_q       <= '0;
            fail_code_q <= FC_NONE;
            fail_idx_q  <= '0;
            fail_got_q  <= '0;
            fail_exp_q  <= '0;
        end else begin
            state_q     <= state_d;
            retire_q    <= retire_d;
            cycle_q     <= cycle_d;
            quiet_q     <= quiet_d;
            idx_q       <= idx_d;
            fail_code_q <= fail_code_d;
            fail_idx_q  <= fail_idx_d;
            fail_got_q  <= fail_got_d;
            fail_exp_q  <= fail_exp_d;
        end
    end

    // Entry 0 is never written, so x0 always reads back as zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) shadow_q[i] <= '0;
        end else if (start_run) begin
            for (int i = 0; i < NREG; i++) shadow_q[i] <= '0;
        end else if ((state_q == S_RUN) && wb_en && (wb_rd != '0)) begin
            shadow_q[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            exp_vld_q          <= '0;
        else if (exp_accept) exp_vld_q[exp_idx] <= 1'b1;
    end

    // NOTE: expected values need no reset; their valid bits gate every use.
    always_ff @(posedge clk) begin
        if (exp_accept) exp_val_q[exp_idx] <= exp_val;
    end

    assign busy         = (state_q == S_RUN) || (state_q == S_CHECK);
    assign done         = (state_q == S_DONE);
    assign pass         = (state_q == S_DONE) && (fail_code_q == FC_NONE);
    assign fail_code    = fail_code_q;
    assign fail_idx     = fail_idx_q;
    assign fail_got     = fail_got_q;
    assign fail_exp     = fail_exp_q;
    assign retire_count = retire_q;
    assign cycle_count  = cycle_q;

endmodule
